riscv_mem_arbiter3: RTL and testbench

- Shares one val/rdy memory port among three requesters: instruction fetch port 0, instruction fetch port 1, and the data port.
- Lets the dual-fetch core run against a single-port memory or cache instead of the triple-port test memory.
- Request path is combinational with round-robin or fixed-priority grant.
- Response routing uses an in-order tag queue that records which requester owns each outstanding request.

---
 rtl/riscv_mem_arbiter3_pkg.sv | 30 +++
 rtl/riscv_mem_arb_tag_queue.sv | 65 ++++++
 rtl/riscv_mem_arbiter3.sv | 160 ++++++++++++++++
 tb/tb_riscv_mem_arbiter3.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arbiter3_pkg.sv
// Shared definitions for the three-way memory arbiter: message-size macros,
// port index constants, tag type and the round-robin successor helper.

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + 2 + (d_))
`endif

`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + 2 + (d_))
`endif

package riscv_mem_arbiter3_pkg;

    localparam int unsigned RISCV_ARB_TAG_W       = 2;
    localparam int unsigned RISCV_ARB_NPORTS      = 3;
    localparam int unsigned RISCV_ARB_REQ_MSG_SZ  = `VC_MEM_REQ_MSG_SZ(32, 32);
    localparam int unsigned RISCV_ARB_RESP_MSG_SZ = `VC_MEM_RESP_MSG_SZ(32);

    typedef logic [RISCV_ARB_TAG_W-1:0] arb_tag_t;

    localparam arb_tag_t RISCV_ARB_PORT_IMEM0 = 2'd0;
    localparam arb_tag_t RISCV_ARB_PORT_IMEM1 = 2'd1;
    localparam arb_tag_t RISCV_ARB_PORT_DMEM  = 2'd2;

    // Next port index in round-robin order, wrapping 2 -> 0.
    function automatic arb_tag_t rr_next(input arb_tag_t idx);
        return (idx == RISCV_ARB_PORT_DMEM) ? RISCV_ARB_PORT_IMEM0 : arb_tag_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/riscv_mem_arb_tag_queue.sv
// In-order FIFO of requester tags for outstanding memory requests.
// Ports: clk, reset (async, active-high); push/push_tag enqueue a tag,
// pop dequeues the head; head, full, empty report queue state.
// No bypass: a pop frees a slot only from the following cycle.

module riscv_mem_arb_tag_queue
    import riscv_mem_arbiter3_pkg::*;
#(
    parameter int unsigned p_depth = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  arb_tag_t push_tag,
    input  logic     pop,
    output arb_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    arb_tag_t         mem [p_depth];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(p_depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Tag storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter3.sv
// Shares one val/rdy memory port among imem0, imem1 and dmem requesters.
// Ports: clk, reset (async, active-high); reqN_msg/val/rdy requester
// inputs; respN_msg/val responses (requesters always ready); memreq_* and
// memresp_* the shared memory port (arbiter always ready for responses);
// err sticky flag for responses with no outstanding tag; grant_cntN
// accepted-request counters. Grant and response steering are combinational;
// a tag queue remembers which requester owns each outstanding request.

module riscv_mem_arbiter3
    import riscv_mem_arbiter3_pkg::*;
#(
    parameter int unsigned p_req_msg_sz      = RISCV_ARB_REQ_MSG_SZ,
    parameter int unsigned p_resp_msg_sz     = RISCV_ARB_RESP_MSG_SZ,
    parameter int unsigned p_max_outstanding = 4,
    parameter int unsigned p_fixed_prio      = 0
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [p_req_msg_sz-1:0]  req0_msg,
    input  logic                     req0_val,
    output logic                     req0_rdy,
    input  logic [p_req_msg_sz-1:0]  req1_msg,
    input  logic                     req1_val,
    output logic                     req1_rdy,
    input  logic [p_req_msg_sz-1:0]  req2_msg,
    input  logic                     req2_val,
    output logic                     req2_rdy,

    output logic [p_resp_msg_sz-1:0] resp0_msg,
    output logic                     resp0_val,
    output logic [p_resp_msg_sz-1:0] resp1_msg,
    output logic                     resp1_val,
    output logic [p_resp_msg_sz-1:0] resp2_msg,
    output logic                     resp2_val,

    output logic [p_req_msg_sz-1:0]  memreq_msg,
    output logic                     memreq_val,
    input  logic                     memreq_rdy,
    input  logic [p_resp_msg_sz-1:0] memresp_msg,
    input  logic                     memresp_val,

    output logic                     err,
    output logic [31:0]              grant_cnt0,
    output logic [31:0]              grant_cnt1,
    output logic [31:0]              grant_cnt2
);

    logic [2:0] req_val_vec;
    arb_tag_t   rr_ptr;
    arb_tag_t   gnt_idx;
    logic       gnt_any;
    logic [2:0] gnt;
    logic       fire;
    logic       resp_hit;
    arb_tag_t   q_head;
    logic       q_full;
    logic       q_empty;

    assign req_val_vec = {req2_val, req1_val, req0_val};

    // Grant selection: fixed dmem > imem0 > imem1, or round-robin from rr_ptr.
    always_comb begin
        arb_tag_t cand;
        gnt_idx = RISCV_ARB_PORT_IMEM0;
        gnt_any = 1'b0;
        cand    = rr_ptr;
        if (p_fixed_prio != 0) begin
            if (req2_val) begin
                gnt_idx = RISCV_ARB_PORT_DMEM;
                gnt_any = 1'b1;
            end else if (req0_val) begin
                gnt_idx = RISCV_ARB_PORT_IMEM0;
                gnt_any = 1'b1;
            end else if (req1_val) begin
                gnt_idx = RISCV_ARB_PORT_IMEM1;
                gnt_any = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < RISCV_ARB_NPORTS; k++) begin
                if (!gnt_any && req_val_vec[cand]) begin
                    gnt_idx = cand;
                    gnt_any = 1'b1;
                end
                cand = rr_next(cand);
            end
        end
    end

    assign gnt = gnt_any ? (3'b001 << gnt_idx) : 3'b000;

    // Request mux; all-zero message when nothing is granted.
    always_comb begin
        memreq_msg = '0;
        if (gnt_any) begin
            case (gnt_idx)
                RISCV_ARB_PORT_IMEM0: memreq_msg = req0_msg;
                RISCV_ARB_PORT_IMEM1: memreq_msg = req1_msg;
                RISCV_ARB_PORT_DMEM:  memreq_msg = req2_msg;
                default:              memreq_msg = '0;
            endcase
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign memreq_val = ~reset & gnt_any & ~q_full;
    assign req0_rdy   = ~reset & gnt[0] & memreq_rdy & ~q_full;
    assign req1_rdy   = ~reset & gnt[1] & memreq_rdy & ~q_full;
    assign req2_rdy   = ~reset & gnt[2] & memreq_rdy & ~q_full;
    assign fire       = memreq_val & memreq_rdy;

    // Responses: data broadcast, valid steered by the oldest outstanding tag.
    assign resp_hit  = ~reset & memresp_val & ~q_empty;
    assign resp0_msg = memresp_msg;
    assign resp1_msg = memresp_msg;
    assign resp2_msg = memresp_msg;
    assign resp0_val = resp_hit & (q_head == RISCV_ARB_PORT_IMEM0);
    assign resp1_val = resp_hit & (q_head == RISCV_ARB_PORT_IMEM1);
    assign resp2_val = resp_hit & (q_head == RISCV_ARB_PORT_DMEM);

    riscv_mem_arb_tag_queue #(
        .p_depth (p_max_outstanding)
    ) u_tag_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (fire),
        .push_tag (gnt_idx),
        .pop      (resp_hit),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Round-robin pointer, sticky error and per-port grant counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= RISCV_ARB_PORT_IMEM0;
            err        <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            grant_cnt2 <= '0;
        end else begin
            if (fire) begin
                if (p_fixed_prio == 0) begin
                    rr_ptr <= rr_next(gnt_idx);
                end
                case (gnt_idx)
                    RISCV_ARB_PORT_IMEM0: grant_cnt0 <= grant_cnt0 + 32'd1;
                    RISCV_ARB_PORT_IMEM1: grant_cnt1 <= grant_cnt1 + 32'd1;
                    RISCV_ARB_PORT_DMEM:  grant_cnt2 <= grant_cnt2 + 32'd1;
                    default:              ;
                endcase
            end
            if (memresp_val && q_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter3.sv
// Bench for riscv_mem_arbiter3: a round-robin and a fixed-priority instance
// share stimulus and are compared every cycle against a queue-based model.

module tb_riscv_mem_arbiter3;
    import riscv_mem_arbiter3_pkg::*;

    localparam int unsigned REQ_W  = 67;
    localparam int unsigned RESP_W = 35;
    localparam int          DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [REQ_W-1:0]  req_msg [3];
    logic [2:0]        req_val;
    logic              memreq_rdy;
    logic              memresp_val;
    logic [RESP_W-1:0] memresp_msg;

    logic [REQ_W-1:0]  memreq_msg_o [2];
    logic              memreq_val_o [2];
    logic [2:0]        rdy_o        [2];
    logic [2:0]        rv_o         [2];
    logic [RESP_W-1:0] rmsg_o       [2][3];
    logic              err_o        [2];
    logic [31:0]       cnt_o        [2][3];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic r0, r1, r2, v0, v1, v2;
        riscv_mem_arbiter3 #(
            .p_req_msg_sz      (REQ_W),
            .p_resp_msg_sz     (RESP_W),
            .p_max_outstanding (DEPTH),
            .p_fixed_prio      (g)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .req0_msg    (req_msg[0]),
            .req0_val    (req_val[0]),
            .req0_rdy    (r0),
            .req1_msg    (req_msg[1]),
            .req1_val    (req_val[1]),
            .req1_rdy    (r1),
            .req2_msg    (req_msg[2]),
            .req2_val    (req_val[2]),
            .req2_rdy    (r2),
            .resp0_msg   (rmsg_o[g][0]),
            .resp0_val   (v0),
            .resp1_msg   (rmsg_o[g][1]),
            .resp1_val   (v1),
            .resp2_msg   (rmsg_o[g][2]),
            .resp2_val   (v2),
            .memreq_msg  (memreq_msg_o[g]),
            .memreq_val  (memreq_val_o[g]),
            .memreq_rdy  (memreq_rdy),
            .memresp_msg (memresp_msg),
            .memresp_val (memresp_val),
            .err         (err_o[g]),
            .grant_cnt0  (cnt_o[g][0]),
            .grant_cnt1  (cnt_o[g][1]),
            .grant_cnt2  (cnt_o[g][2])
        );
        assign rdy_o[g] = {r2, r1, r0};
        assign rv_o[g]  = {v2, v1, v0};
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one tag queue per instance (0 = round-robin, 1 = fixed).
    int          q_rr [$];
    int          q_fp [$];
    int          m_rr_ptr;
    bit          m_err [2];
    logic [31:0] m_cnt [2][3];
    logic [2:0]  obs_rdy  [2];
    logic        obs_mval [2];

    function automatic int qsize(int i);
        return (i == 0) ? q_rr.size() : q_fp.size();
    endfunction

    function automatic int qhead(int i);
        return (i == 0) ? q_rr[0] : q_fp[0];
    endfunction

    task automatic model_reset();
        q_rr.delete();
        q_fp.delete();
        m_rr_ptr = 0;
        for (int i = 0; i < 2; i++) begin
            m_err[i] = 1'b0;
            for (int n = 0; n < 3; n++) m_cnt[i][n] = 32'd0;
        end
    endtask

    // Expected grant index, or -1 when nobody is requesting.
    function automatic int exp_gnt(int i, logic [2:0] v);
        if (i == 1) begin
            if (v[2]) return 2;
            if (v[0]) return 0;
            if (v[1]) return 1;
            return -1;
        end
        for (int k = 0; k < 3; k++) begin
            if (v[(m_rr_ptr + k) % 3]) return (m_rr_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s memreq_val[%0d]", tag, i), 128'(memreq_val_o[i]), 128'(0));
            check($sformatf("%s rdy[%0d]", tag, i), 128'(rdy_o[i]), 128'(0));
            check($sformatf("%s resp_val[%0d]", tag, i), 128'(rv_o[i]), 128'(0));
            check($sformatf("%s err[%0d]", tag, i), 128'(err_o[i]), 128'(0));
            for (int n = 0; n < 3; n++)
                check($sformatf("%s cnt[%0d][%0d]", tag, i, n), 128'(cnt_o[i][n]), 128'(0));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_val     = 3'b111;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        reset       = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_edge");
        @(negedge clk);
        reset       = 1'b0;
        req_val     = 3'b000;
        memresp_val = 1'b0;
        model_reset();
    endtask

    task automatic rand_msgs();
        for (int n = 0; n < 3; n++) req_msg[n] = REQ_W'({$urandom(), $urandom(), $urandom()});
        memresp_msg = RESP_W'({$urandom(), $urandom()});
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update model, check registers.
    task automatic step(input logic [2:0] v, input logic mrdy, input logic rv);
        int g [2];
        bit fire [2];
        bit pop  [2];
        bit eset [2];
        @(negedge clk);
        req_val     = v;
        memreq_rdy  = mrdy;
        memresp_val = rv;
        #1;
        for (int i = 0; i < 2; i++) begin
            bit               full;
            bit               hit;
            logic [REQ_W-1:0] emsg;
            obs_rdy[i]  = rdy_o[i];
            obs_mval[i] = memreq_val_o[i];
            g[i] = exp_gnt(i, v);
            full = (qsize(i) == DEPTH);
            check($sformatf("memreq_val[%0d]", i), 128'(memreq_val_o[i]), 128'((g[i] >= 0) && !full));
            emsg = (g[i] >= 0) ? req_msg[g[i]] : '0;
            check($sformatf("memreq_msg[%0d]", i), 128'(memreq_msg_o[i]), 128'(emsg));
            for (int n = 0; n < 3; n++)
                check($sformatf("req%0d_rdy[%0d]", n, i), 128'(rdy_o[i][n]),
                      128'((g[i] == n) && mrdy && !full));
            hit = rv && (qsize(i) > 0);
            for (int n = 0; n < 3; n++) begin
                bit ev;
                ev = hit && (qhead(i) == n);
                check($sformatf("resp%0d_val[%0d]", n, i), 128'(rv_o[i][n]), 128'(ev));
                if (ev) check($sformatf("resp%0d_msg[%0d]", n, i), 128'(rmsg_o[i][n]), 128'(memresp_msg));
            end
            fire[i] = (g[i] >= 0) && !full && mrdy;
            pop[i]  = hit;
            eset[i] = rv && (qsize(i) == 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (pop[i]) begin
                if (i == 0) void'(q_rr.pop_front());
                else        void'(q_fp.pop_front());
            end
            if (fire[i]) begin
                if (i == 0) q_rr.push_back(g[i]);
                else        q_fp.push_back(g[i]);
                m_cnt[i][g[i]] = m_cnt[i][g[i]] + 32'd1;
                if (i == 0) m_rr_ptr = (g[i] + 1) % 3;
            end
            if (eset[i]) m_err[i] = 1'b1;
            check($sformatf("err[%0d]", i), 128'(err_o[i]), 128'(m_err[i]));
            for (int n = 0; n < 3; n++)
                check($sformatf("grant_cnt%0d[%0d]", n, i), 128'(cnt_o[i][n]), 128'(m_cnt[i][n]));
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_val     = 3'b000;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        rand_msgs();
        model_reset();

        // Single dmem request, response two cycles later.
        do_reset();
        req_msg[2]  = {1'b0, 32'h0000_2000, 2'd0, 32'h0};
        memresp_msg = {1'b0, 2'd0, 32'hCAFE_F00D};
        step(3'b100, 1'b1, 1'b0);
        check("single memreq_val", 128'(obs_mval[0]), 128'(1));
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b1);
        check("single grant_cnt2", 128'(cnt_o[0][2]), 128'(32'd1));

        // Round-robin fairness vs fixed priority, all three requesting.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rand_msgs();
            step(3'b111, 1'b1, k > 0);
            check($sformatf("rr_order%0d", k), 128'(obs_rdy[0]), 128'(3'b001 << (k % 3)));
            check($sformatf("fp_order%0d", k), 128'(obs_rdy[1]), 128'(3'b100));
        end
        for (int n = 0; n < 3; n++)
            check($sformatf("rr_cnt%0d", n), 128'(cnt_o[0][n]), 128'(32'd2));
        check("fp_cnt2", 128'(cnt_o[1][2]), 128'(32'd6));

        // Full queue: four accepted, then stalled until a response frees a slot.
        do_reset();
        for (int k = 0; k < 4; k++) step(3'b111, 1'b1, 1'b0);
        step(3'b111, 1'b1, 1'b0);
        check("full memreq_val", 128'(obs_mval[0]), 128'(0));
        check("full rdy", 128'(obs_rdy[0]), 128'(0));
        step(3'b111, 1'b1, 1'b1);
        check("full_pop memreq_val", 128'(obs_mval[0]), 128'(0));
        step(3'b111, 1'b1, 1'b0);
        check("reopen memreq_val", 128'(obs_mval[0]), 128'(1));

        // Response with nothing outstanding.
        do_reset();
        step(3'b000, 1'b1, 1'b1);
        check("stray err", 128'(err_o[0]), 128'(1));
        step(3'b000, 1'b0, 1'b0);
        step(3'b011, 1'b1, 1'b0);
        check("stray err sticky", 128'(err_o[0]), 128'(1));

        // Asynchronous reset with three requests in flight.
        do_reset();
        for (int k = 0; k < 3; k++) step(3'b111, 1'b1, 1'b0);
        @(negedge clk);
        req_val = 3'b111;
        #1;
        check("pre_async memreq_val", 128'(memreq_val_o[0]), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        reset   = 1'b0;
        req_val = 3'b000;
        model_reset();
        step(3'b000, 1'b1, 1'b1);

        // Randomized traffic with periodic resets.
        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 0) do_reset();
            rand_msgs();
            step(3'($urandom_range(0, 7)), ($urandom % 4) != 0, ($urandom % 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
